fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_ALIGN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_ALIGN);
    endfunction

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(INSTR_ALIGN - 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshake bundle of the fetch unit.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic            instr_ready;
    logic            pcsrc;
    logic [XLEN-1:0] pctarget;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, pcplus4,
        input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, pcsrc, pctarget
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, pcplus4,
        output imem_gnt, imem_rvalid, imem_rdata, instr_ready, pcsrc, pctarget
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, two-entry buffer, redirect on taken branch.
//   state | meaning
//   IDLE  | buffer full, no request issued
//   REQ   | imem_req high at addr_q, waiting for grant
//   WAIT  | granted, waiting for rvalid (dropped if stale)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e    state_q;
    logic            imem_req_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic            stale_q;

    logic [1:0]      count;
    logic [1:0]      count_after;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            instr_valid;
    logic            pop;
    logic            redirect;
    logic            gnt_take;
    logic            rsp_take;
    logic            push;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && bus.instr_ready;
    assign redirect    = pop && bus.pcsrc;
    assign gnt_take    = (state_q == REQ) && bus.imem_gnt;
    assign rsp_take    = (state_q == WAIT) && bus.imem_rvalid;
    // A response coinciding with a redirect belongs to the old path.
    assign push        = rsp_take && !stale_q && !redirect;

    assign push_data.pc    = req_pc_q;
    assign push_data.instr = bus.imem_rdata;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = pc_align(bus.pctarget);
        end else if (gnt_take && !stale_q) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end
    end

    always_comb begin
        if (redirect) begin
            count_after = 2'd0;
        end else begin
            count_after = count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            stale_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;

            if (rsp_take) begin
                stale_q <= 1'b0;
            end else if (redirect && (state_q != IDLE)) begin
                stale_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (count < 2'd2) begin
                        state_q    <= REQ;
                        imem_req_q <= 1'b1;
                        addr_q     <= fetch_pc_d;
                    end
                end
                REQ: begin
                    // Address is held even across a redirect; the grant is still honoured.
                    if (bus.imem_gnt) begin
                        state_q    <= WAIT;
                        imem_req_q <= 1'b0;
                        req_pc_q   <= addr_q;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (count_after < 2'd2) begin
                            state_q    <= REQ;
                            imem_req_q <= 1'b1;
                            addr_q     <= fetch_pc_d;
                        end else begin
                            state_q    <= IDLE;
                            imem_req_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect),
        .count_o     (count),
        .head_o      (head)
    );

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr_valid ? head.instr : '0;
    assign bus.pc          = instr_valid ? head.pc : '0;
    assign bus.pcplus4     = instr_valid ? pc_next(head.pc) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/redirect traffic.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          gnt_dly  = 0;
    int          rv_dly   = 1;
    bit          mem_pend = 1'b0;
    int          gcnt     = 0;
    int          rcnt     = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] exp_pc   = RESET_PC;
    int          pops     = 0;
    int          cyc      = 0;
    bit          prev_req = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    // Memory: grant after gnt_dly cycles of request, data rv_dly cycles after grant.
    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b0;
            if (rst) begin
                mem_pend = 1'b0;
                gcnt     = 0;
            end else if (mem_pend) begin
                rcnt--;
                if (rcnt <= 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(mem_addr);
                    mem_pend        = 1'b0;
                end
            end else if (bus.imem_req) begin
                if (gcnt >= gnt_dly) begin
                    bus.imem_gnt = 1'b1;
                    mem_pend     = 1'b1;
                    rcnt         = rv_dly;
                    mem_addr     = bus.imem_addr;
                    gcnt         = 0;
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // One cycle: drive decode-side inputs, check protocol and any consumed instruction against the program-order model.
    task automatic step(input bit rdy, input bit psrc, input logic [31:0] tgt);
        bus.instr_ready = rdy;
        bus.pcsrc       = psrc;
        bus.pctarget    = tgt;
        chk("one_outstanding", 32'(bus.imem_req && mem_pend), 32'd0);
        if (prev_req && !bus.imem_gnt) begin
            chk("req_hold", 32'(bus.imem_req), 32'd1);
            chk("addr_hold", bus.imem_addr, prev_addr);
        end
        if (bus.imem_req) chk("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
        prev_req  = bus.imem_req;
        prev_addr = bus.imem_addr;
        if (bus.instr_valid && rdy) begin
            chk("pop_pc", bus.pc, exp_pc);
            chk("pop_instr", bus.instr, mem_word(exp_pc));
            chk("pop_pcplus4", bus.pcplus4, exp_pc + 32'd4);
            exp_pc = psrc ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
            pops++;
        end
        @(negedge clk);
        cyc++;
    endtask

    int          k;
    int          pop_cyc[$];
    bit          r_rdy;
    bit          r_src;
    logic [31:0] r_tgt;

    initial begin
        bus.instr_ready = 1'b0;
        bus.pcsrc       = 1'b0;
        bus.pctarget    = '0;

        // Reset values, release, 1-cycle memory at full downstream rate.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_pcplus4", bus.pcplus4, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        rst = 1'b0;
        exp_pc = RESET_PC;
        prev_req = 1'b0;
        step(1'b1, 1'b0, '0);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, RESET_PC);
        pops = 0;
        k = 0;
        while (pops < 4 && k < 40) begin
            if (bus.instr_valid) pop_cyc.push_back(cyc);
            step(1'b1, 1'b0, '0);
            k++;
        end
        chk("seq_count", 32'(pops), 32'd4);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("throughput_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
        end

        // Downstream stall fills the buffer, then drain and refetch.
        rst = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC;
        prev_req = 1'b0;
        repeat (10) step(1'b0, 1'b0, '0);
        chk("stall_valid", 32'(bus.instr_valid), 32'd1);
        chk("stall_pc", bus.pc, RESET_PC);
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("drain_pc", bus.pc, RESET_PC + 32'd4);
        k = 0;
        while (!bus.imem_req && k < 10) begin
            step(1'b0, 1'b0, '0);
            k++;
        end
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", bus.imem_addr, RESET_PC + 32'd8);

        // Redirect while fetch of 8 is in WAIT with its response arriving the same cycle.
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0100);
        k = 0;
        while (!bus.instr_valid && k < 20) begin
            step(1'b0, 1'b0, '0);
            k++;
        end
        chk("redir_valid", 32'(bus.instr_valid), 32'd1);
        chk("redir_pc", bus.pc, 32'h0000_0100);
        chk("redir_pcplus4", bus.pcplus4, 32'h0000_0104);

        // Unaligned redirect while a slow response is outstanding: stale path.
        rv_dly = 3;
        k = 0;
        while (!(mem_pend && bus.instr_valid) && k < 20) begin
            step(1'b0, 1'b0, '0);
            k++;
        end
        chk("stale_setup", 32'(mem_pend && bus.instr_valid), 32'd1);
        step(1'b1, 1'b1, 32'h0000_0103);
        k = 0;
        while (!bus.imem_req && k < 12) begin
            step(1'b0, 1'b0, '0);
            k++;
        end
        chk("stale_req", 32'(bus.imem_req), 32'd1);
        chk("stale_addr", bus.imem_addr, 32'h0000_0100);
        chk("stale_latency", 32'(k <= rv_dly + 2), 32'd1);

        // Reset in WAIT coinciding with a redirect.
        k = 0;
        while (!(mem_pend && bus.instr_valid) && k < 30) begin
            step(1'b0, 1'b0, '0);
            k++;
        end
        chk("rstwait_setup", 32'(mem_pend && bus.instr_valid), 32'd1);
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        bus.pcsrc       = 1'b1;
        bus.pctarget    = 32'h0000_0200;
        @(negedge clk);
        chk("rstwait_valid", 32'(bus.instr_valid), 32'd0);
        chk("rstwait_req", 32'(bus.imem_req), 32'd0);
        chk("rstwait_pc", bus.pc, 32'd0);
        bus.instr_ready = 1'b0;
        bus.pcsrc       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RESET_PC;
        prev_req = 1'b0;
        k = 0;
        while (!bus.imem_req && k < 10) begin
            step(1'b0, 1'b0, '0);
            k++;
        end
        chk("postrst_req", 32'(bus.imem_req), 32'd1);
        chk("postrst_addr", bus.imem_addr, RESET_PC);

        // Slow memory, random downstream readiness and redirects.
        gnt_dly = 3;
        rv_dly  = 4;
        pops    = 0;
        k = 0;
        while (pops < 40 && k < 3000) begin
            r_rdy = 1'($urandom_range(0, 1));
            r_src = ($urandom_range(0, 5) == 0);
            r_tgt = $urandom & 32'h0000_0FFF;
            step(r_rdy, r_src, r_tgt);
            k++;
        end
        chk("random_pops", 32'(pops >= 40), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
